// File: rtl/axi_bram_slave.sv
// axi_bram_slave
//   AXI4 responder backed by on-chip block RAM, using the reduced channel set
//   (AW/W/B/AR/R, INCR bursts only, no id/size/resp). Serves exactly one burst
//   at a time, so reads and writes never overlap.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   awvalid/awready/awaddr/awlen  write burst request (len = beats - 1)
//   wvalid/wready/wlast/wdata     write data beats (wlast only checked)
//   bvalid/bready                 write response
//   arvalid/arready/araddr/arlen  read burst request (len = beats - 1)
//   rvalid/rready/rlast/rdata     read data beats
//   werr                          sticky flag: wlast disagreed with beat count
//
// Word index = addr[D_LEVEL +: MEM_AW]; upper address bits alias, the index
// wraps modulo 2^MEM_AW within a burst. Memory contents survive reset.
module axi_bram_slave #(
    parameter int A_WIDTH = 26,
    parameter int D_LEVEL = 1,
    parameter int D_WIDTH = 16,
    parameter int MEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               awvalid,
    output logic               awready,
    input  logic [A_WIDTH-1:0] awaddr,
    input  logic [7:0]         awlen,
    input  logic               wvalid,
    output logic               wready,
    input  logic               wlast,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               bvalid,
    input  logic               bready,
    input  logic               arvalid,
    output logic               arready,
    input  logic [A_WIDTH-1:0] araddr,
    input  logic [7:0]         arlen,
    output logic               rvalid,
    input  logic               rready,
    output logic               rlast,
    output logic [D_WIDTH-1:0] rdata,
    output logic               werr
);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t state, state_next;

    logic [D_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    logic [MEM_AW-1:0] idx;
    logic [7:0]        len;
    logic [7:0]        cnt;
    logic              rd_done;      // last word of the read burst already fetched
    logic              prefer_read;  // round-robin: write was granted last
    logic              grant_w, grant_r;
    logic              aw_hs, ar_hs, w_beat, w_end, fetch, r_end;
    logic              unused_addr;

    assign unused_addr = ^{awaddr, araddr};

    assign aw_hs  = awready & awvalid;
    assign ar_hs  = arready & arvalid;
    assign w_beat = wready & wvalid;
    assign w_end  = w_beat & (cnt == len);
    // Fetch into the output register whenever it is empty or being drained.
    assign fetch  = (state == RDATA) & ~rd_done & (~rvalid | rready);
    assign r_end  = rvalid & rready & rlast;

    // Arbitration is only evaluated while no grant is outstanding, so an
    // asserted awready/arready stays put until its handshake completes.
    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (state == IDLE && !awready && !arready) begin
            if (awvalid && arvalid) begin
                grant_r = prefer_read;
                grant_w = ~prefer_read;
            end else if (awvalid) begin
                grant_w = 1'b1;
            end else if (arvalid) begin
                grant_r = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (state)
            IDLE: begin
                if (aw_hs)      state_next = WDATA;
                else if (ar_hs) state_next = RDATA;
            end
            WDATA: begin
                wready = 1'b1;
                if (w_end) state_next = WRESP;
            end
            WRESP: begin
                bvalid = 1'b1;
                if (bready) state_next = IDLE;
            end
            RDATA: begin
                if (r_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            awready     <= 1'b0;
            arready     <= 1'b0;
            idx         <= '0;
            len         <= '0;
            cnt         <= '0;
            rd_done     <= 1'b0;
            prefer_read <= 1'b0;
            rvalid      <= 1'b0;
            rlast       <= 1'b0;
            rdata       <= '0;
            werr        <= 1'b0;
        end else begin
            state <= state_next;

            if (grant_w || grant_r) begin
                awready     <= grant_w;
                arready     <= grant_r;
                prefer_read <= grant_w;
            end

            if (aw_hs) begin
                awready <= 1'b0;
                idx     <= awaddr[D_LEVEL +: MEM_AW];
                len     <= awlen;
                cnt     <= '0;
            end

            if (ar_hs) begin
                arready <= 1'b0;
                idx     <= araddr[D_LEVEL +: MEM_AW];
                len     <= arlen;
                cnt     <= '0;
                rd_done <= 1'b0;
            end

            if (w_beat) begin
                idx <= idx + MEM_AW'(1);
                cnt <= cnt + 8'd1;
                if (wlast != (cnt == len)) werr <= 1'b1;
            end

            // Read side shares idx/cnt as the fetch pointer and fetch count.
            if (fetch) begin
                rdata  <= mem[idx];
                rvalid <= 1'b1;
                rlast  <= (cnt == len);
                idx    <= idx + MEM_AW'(1);
                cnt    <= cnt + 8'd1;
                if (cnt == len) rd_done <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat) mem[idx] <= wdata;
    end

endmodule

// File: tb/tb_axi_bram_slave.sv
// tb_axi_bram_slave
//   Randomised bench for axi_bram_slave with a word-array reference memory
//   and a scoreboard: drivers push expected R beats / B responses, a negedge
//   monitor pops and compares on every handshake.
module tb_axi_bram_slave;

    localparam int AW    = 26;
    localparam int DL    = 1;
    localparam int DW    = 16;
    localparam int MAW   = 10;
    localparam int DEPTH = 1 << MAW;
    localparam byte GW   = 8'h57;
    localparam byte GR   = 8'h52;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic          wvalid = 1'b0, wready, wlast = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          bvalid, bready = 1'b0;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic          rvalid, rready = 1'b0, rlast;
    logic [DW-1:0] rdata;
    logic          werr;

    always #5 clk = ~clk;

    axi_bram_slave #(
        .A_WIDTH(AW), .D_LEVEL(DL), .D_WIDTH(DW), .MEM_AW(MAW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
        .werr(werr)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } rexp_t;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [DW-1:0] model [DEPTH];
    rexp_t         exp_r [$];
    int            exp_b = 0;
    byte           grant_log [$];
    bit            bp_en = 1'b1;
    int            ar_cyc = 0;
    int            first_lat = -1;
    bit            wait_first = 1'b0;
    int            last_r_cyc = -1;
    int            max_r_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ready backpressure: random when enabled, otherwise always ready.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            rready = 1'($urandom_range(0, 1));
            bready = 1'($urandom_range(0, 1));
        end else begin
            rready = 1'b1;
            bready = 1'b1;
        end
    end

    // Monitor: sampled at negedge, a visible valid&ready handshakes at the next posedge.
    logic          prev_rstall = 1'b0, prev_bstall = 1'b0, prev_rlast = 1'b0;
    logic [DW-1:0] prev_rdata = '0;

    always @(negedge clk) begin
        rexp_t e;
        if (!rstn) begin
            prev_rstall = 1'b0;
            prev_bstall = 1'b0;
            wait_first  = 1'b0;
        end else begin
            if (prev_rstall) begin
                check("r_hold_valid", 32'(rvalid), 32'd1);
                check("r_hold_data", 32'(rdata), 32'(prev_rdata));
                check("r_hold_last", 32'(rlast), 32'(prev_rlast));
            end
            if (prev_bstall) check("b_hold_valid", 32'(bvalid), 32'd1);
            if (wait_first && rvalid) begin
                first_lat  = cyc - ar_cyc;
                wait_first = 1'b0;
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL r_unexpected: got beat %0h, expected no beat", rdata);
                end else begin
                    e = exp_r.pop_front();
                    check("r_data", 32'(rdata), 32'(e.d));
                    check("r_last", 32'(rlast), 32'(e.l));
                end
                if (last_r_cyc >= 0 && cyc - last_r_cyc > max_r_gap) max_r_gap = cyc - last_r_cyc;
                last_r_cyc = cyc;
            end
            if (bvalid && bready) begin
                check("b_pending", 32'(exp_b > 0), 32'd1);
                if (exp_b > 0) exp_b--;
            end
            if (wready || rvalid) check("no_overlap", 32'(wready && rvalid), 32'd0);
            if (awvalid && awready) grant_log.push_back(GW);
            if (arvalid && arready) begin
                grant_log.push_back(GR);
                ar_cyc     = cyc;
                wait_first = 1'b1;
            end
            prev_rstall = rvalid && !rready;
            prev_rdata  = rdata;
            prev_rlast  = rlast;
            prev_bstall = bvalid && !bready;
        end
    end

    function automatic logic [AW-1:0] mk_addr(input int unsigned idx);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[DL +: MAW] = MAW'(idx);
        return a;
    endfunction

    task automatic wait_neg(input int sel, input string nm);
        int t = 0;
        bit hit = 1'b0;
        while (!hit) begin
            @(negedge clk);
            case (sel)
                0:       hit = awready;
                1:       hit = wready;
                default: hit = arready;
            endcase
            if (!hit) begin
                t++;
                if (t > 4000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s_timeout: got no ready in %0d cycles, required ready", nm, t);
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int unsigned idx, input int len, input int err_beat,
                            input bit directed, input logic [DW-1:0] dbase, input bit gaps);
        int t = 0;
        awaddr  = mk_addr(idx);
        awlen   = 8'(len);
        awvalid = 1'b1;
        wait_neg(0, "aw");
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                wvalid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            wdata  = directed ? dbase + DW'(i) : DW'($urandom);
            wlast  = (err_beat >= 0) ? (i == err_beat) : (i == len);
            model[(idx + i) % DEPTH] = wdata;
            wvalid = 1'b1;
            wait_neg(1, "w");
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        exp_b++;
        while (exp_b != 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 4000) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_timeout: got %0d responses outstanding, required 0", exp_b);
                exp_b = 0;
            end
        end
    endtask

    task automatic push_read(input int unsigned idx, input int len);
        for (int i = 0; i <= len; i++)
            exp_r.push_back('{d: model[(idx + i) % DEPTH], l: (i == len)});
    endtask

    task automatic do_read(input int unsigned idx, input int len);
        int t = 0;
        push_read(idx, len);
        araddr  = mk_addr(idx);
        arlen   = 8'(len);
        arvalid = 1'b1;
        wait_neg(2, "ar");
        arvalid = 1'b0;
        while (exp_r.size() != 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 4000) begin
                n_cmp++;
                n_err++;
                $display("FAIL r_timeout: got %0d beats outstanding, required 0", exp_r.size());
                exp_r.delete();
            end
        end
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs: every output stays zero.
        rstn = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            awvalid = 1'($urandom); arvalid = 1'($urandom); wvalid = 1'($urandom);
            wlast   = 1'($urandom); awaddr = AW'($urandom); araddr = AW'($urandom);
            awlen   = 8'($urandom); arlen = 8'($urandom); wdata = DW'($urandom);
            @(negedge clk);
            check("reset_outputs", 32'({awready, wready, bvalid, arready, rvalid, rlast, werr}), 32'd0);
            check("reset_rdata", 32'(rdata), 32'd0);
        end
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_no_grant", 32'({awready, arready}), 32'd0);
        end
        @(posedge clk);
        #1;

        // Give the whole memory known contents.
        for (int k = 0; k < 4; k++) do_write(k * 256, 255, -1, 1'b0, '0, 1'b0);

        // Directed write/readback at byte address 0x10 (index 8).
        bp_en = 1'b0;
        do_write(8, 7, -1, 1'b1, 16'h1000, 1'b0);
        first_lat  = -1;
        max_r_gap  = 0;
        last_r_cyc = -1;
        do_read(8, 7);
        check("first_beat_latency", 32'(first_lat), 32'd2);
        check("r_beat_spacing", 32'(max_r_gap), 32'd1);

        // Index wrap at the top of memory.
        do_write(1022, 3, -1, 1'b0, '0, 1'b0);
        do_read(0, 1);
        do_read(1022, 3);

        // Random traffic under backpressure and write gaps.
        bp_en = 1'b1;
        repeat (20) begin
            do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 15), -1, 1'b0, '0, 1'b1);
            do_read($urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
        end
        do_read($urandom_range(0, DEPTH - 1), 255);
        check("werr_clean", 32'(werr), 32'd0);

        // Contention from a fresh reset: grants must alternate starting with write.
        apply_reset();
        grant_log.delete();
        fork
            begin
                do_write(100, 5, -1, 1'b0, '0, 1'b0);
                do_write(120, 3, -1, 1'b0, '0, 1'b0);
            end
            begin
                do_read(600, 4);
                do_read(700, 2);
            end
        join
        check("grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("grant_order", 32'(grant_log[i]), 32'((i % 2 == 0) ? GW : GR));

        // Early wlast: flag sticks, burst length still follows len.
        do_write(300, 3, 2, 1'b0, '0, 1'b0);
        check("werr_set", 32'(werr), 32'd1);
        do_read(300, 3);

        // Reset in the middle of a read, then a normal read.
        bp_en = 1'b0;
        push_read(500, 15);
        araddr  = mk_addr(500);
        arlen   = 8'd15;
        arvalid = 1'b1;
        wait_neg(2, "ar_abort");
        arvalid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rstn = 1'b0;
        #1;
        check("abort_rvalid", 32'(rvalid), 32'd0);
        check("abort_werr", 32'(werr), 32'd0);
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        do_read(500, 15);
        do_read(300, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
